// File: rtl/alu_mul_seq.sv
// Multi-cycle unsigned 16x16 multiplier (low 16 bits) that drives a shared ALU
// through shift-add iterations: ADD acc+mcand, SHL mcand, SHR mplier.
module alu_mul_seq #(
  parameter logic [15:0] SHL1_CODE = 16'h000F,
  parameter logic [15:0] SHR1_CODE = 16'h8001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ovf,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_IDLE  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [15:0] acc, mcand, mplier;
  logic        ovf_run;

  // Only carry (c) and overflow (v) matter; z and n are left unconnected.
  logic unused_flags;
  assign unused_flags = alu_flags[3] ^ alu_flags[1];

  assign dbg_state = state;

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    alu_op   = OP_IDLE;
    alu_in1  = 16'h0000;
    alu_in2  = 16'h0000;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (b == 16'h0000) state_nx = S_DONE;
          else if (b[0])     state_nx = S_ADD;
          else               state_nx = S_SHL;
        end
      end
      S_ADD: begin
        busy     = 1'b1;
        alu_op   = OP_ADD;
        alu_in1  = acc;
        alu_in2  = mcand;
        state_nx = S_SHL;
      end
      S_SHL: begin
        busy     = 1'b1;
        alu_op   = OP_SHIFT;
        alu_in1  = mcand;
        alu_in2  = SHL1_CODE;
        state_nx = S_SHR;
      end
      S_SHR: begin
        busy    = 1'b1;
        alu_op  = OP_SHIFT;
        alu_in1 = mplier;
        alu_in2 = SHR1_CODE;
        if (alu_out == 16'h0000) state_nx = S_DONE;
        else if (alu_out[0])     state_nx = S_ADD;
        else                     state_nx = S_SHL;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      acc     <= 16'h0000;
      mcand   <= 16'h0000;
      mplier  <= 16'h0000;
      ovf_run <= 1'b0;
      product <= 16'h0000;
      ovf     <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            acc     <= 16'h0000;
            ovf_run <= 1'b0;
            mcand   <= a;
            mplier  <= b;
            if (b == 16'h0000) begin
              product <= 16'h0000;
              ovf     <= 1'b0;
            end
          end
        end
        S_ADD: begin
          acc     <= alu_out;
          ovf_run <= ovf_run | alu_flags[2];
        end
        S_SHL: begin
          // A bit shifted out of mcand only matters if a later add will use it.
          mcand   <= alu_out;
          ovf_run <= ovf_run | (alu_flags[0] & (mplier[15:1] != 15'h0000));
        end
        S_SHR: begin
          mplier <= alu_out;
          if (alu_out == 16'h0000) begin
            product <= acc;
            ovf     <= ovf_run;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
